// File: rtl/adder_tree_sched_pkg.sv
// Shared constants and width helpers for the adder-tree scheduler and its result buffer.
package adder_tree_pkg;

   localparam int unsigned NUM_LEAVES = 8;
   localparam int unsigned LEVEL_BITS = 3;

   typedef int unsigned width_t;

   function automatic width_t sum_width(width_t w);
      return w + LEVEL_BITS;
   endfunction

   // Requester-id width; never zero so a 1-bit id survives degenerate configurations.
   function automatic width_t id_width(width_t n);
      return (n > 1) ? width_t'($clog2(n)) : 1;
   endfunction

endpackage

// File: rtl/adder_tree_sched_if.sv
// Request, tree and result signals of the adder-tree scheduler.
interface adder_tree_sched_if #(
   parameter int unsigned ADDER_WIDTH = 6,
   parameter int unsigned NUM_REQ     = 4
);
   import adder_tree_pkg::*;

   localparam int unsigned OpW  = NUM_LEAVES * ADDER_WIDTH;
   localparam int unsigned SumW = sum_width(ADDER_WIDTH);
   localparam int unsigned IdW  = id_width(NUM_REQ);

   logic [NUM_REQ-1:0]     req_valid;
   logic [NUM_REQ-1:0]     req_ready;
   logic [NUM_REQ*OpW-1:0] req_operands;
   logic                   tree_valid;
   logic [OpW-1:0]         tree_operands;
   logic [SumW-1:0]        tree_sum;
   logic                   res_valid;
   logic                   res_ready;
   logic [SumW-1:0]        res_sum;
   logic [IdW-1:0]         res_id;

   modport slave (
      input  req_valid, req_operands, tree_sum, res_ready,
      output req_ready, tree_valid, tree_operands, res_valid, res_sum, res_id
   );

   modport master (
      output req_valid, req_operands, tree_sum, res_ready,
      input  req_ready, tree_valid, tree_operands, res_valid, res_sum, res_id
   );

endinterface

// File: rtl/adder_tree_res_fifo.sv
// Show-ahead result FIFO; head data reads as zero while empty.
module adder_tree_res_fifo #(
   parameter int unsigned Width = 8,
   parameter int unsigned Depth = 8,
   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
   localparam int unsigned CntW = $clog2(Depth + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [Width-1:0] push_data_i,
   input  logic             pop_ready_i,
   output logic             head_valid_o,
   output logic [Width-1:0] head_data_o,
   output logic [CntW-1:0]  count_o
);

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  count_q, count_d;
   logic             pop;

   assign head_valid_o = (count_q != '0);
   assign pop          = head_valid_o & pop_ready_i;
   assign head_data_o  = head_valid_o ? mem_q[rd_ptr_q] : '0;
   assign count_o      = count_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_i) wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (pop)    rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1;
      if (push_i && !pop)      count_d = count_q + 1'b1;
      else if (!push_i && pop) count_d = count_q - 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_ptr_q] <= push_data_i;
   end

   // Upstream credits must make this unreachable.
   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      push_i |-> (count_q < CntW'(Depth)))
      else $error("push into full result FIFO");

endmodule

// File: rtl/adder_tree_sched.sv
// Round-robin scheduler sharing one pipelined 8-leaf adder tree; tags each issue through the
// tree latency and buffers tagged sums in a credit-protected result FIFO.
module adder_tree_sched
   import adder_tree_pkg::*;
#(
   parameter int unsigned ADDER_WIDTH  = 6,
   parameter int unsigned NUM_REQ      = 4,
   parameter int unsigned TREE_LATENCY = 2,
   parameter int unsigned RES_DEPTH    = 8
) (
   input logic               clk,
   input logic               rst,
   adder_tree_sched_if.slave bus
);

   localparam int unsigned OpW  = NUM_LEAVES * ADDER_WIDTH;
   localparam int unsigned SumW = sum_width(ADDER_WIDTH);
   localparam int unsigned IdW  = id_width(NUM_REQ);
   localparam int unsigned CntW = $clog2(RES_DEPTH + 1);

   typedef logic [IdW-1:0] id_t;

   id_t            last_grant_q, last_grant_d;
   logic           issue_valid_q, issue_valid_d;
   id_t            issue_id_q, issue_id_d;
   logic [OpW-1:0] issue_ops_q, issue_ops_d;
   logic           tag_valid_q [TREE_LATENCY];
   logic           tag_valid_d [TREE_LATENCY];
   id_t            tag_id_q [TREE_LATENCY];
   id_t            tag_id_d [TREE_LATENCY];

   logic [CntW-1:0]     fifo_count;
   logic [IdW+SumW-1:0] head_data;
   int unsigned         inflight;
   logic                credit_ok, grant_found, accept;
   id_t                 grant_id, cand;

   // First valid requester after last_grant, wrapping modulo NUM_REQ.
   always_comb begin
      grant_found = 1'b0;
      grant_id    = last_grant_q;
      cand        = '0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         cand = id_t'((32'(last_grant_q) + k) % NUM_REQ);
         if (!grant_found && bus.req_valid[cand]) begin
            grant_found = 1'b1;
            grant_id    = cand;
         end
      end
   end

   // Credits count the issue register and every tag stage against free FIFO slots.
   always_comb begin
      inflight = 32'(issue_valid_q);
      for (int unsigned i = 0; i < TREE_LATENCY; i++) begin
         if (tag_valid_q[i]) inflight = inflight + 1;
      end
      credit_ok = (32'(fifo_count) + inflight) < RES_DEPTH;
      accept    = credit_ok & grant_found;
   end

   always_comb begin
      bus.req_ready = '0;
      if (accept) bus.req_ready[grant_id] = 1'b1;
   end

   always_comb begin
      last_grant_d  = last_grant_q;
      issue_valid_d = accept;
      issue_id_d    = issue_id_q;
      issue_ops_d   = issue_ops_q;
      if (accept) begin
         last_grant_d = grant_id;
         issue_id_d   = grant_id;
         issue_ops_d  = bus.req_operands[32'(grant_id)*OpW +: OpW];
      end
      tag_valid_d[0] = issue_valid_q;
      tag_id_d[0]    = issue_id_q;
      for (int unsigned i = 1; i < TREE_LATENCY; i++) begin
         tag_valid_d[i] = tag_valid_q[i-1];
         tag_id_d[i]    = tag_id_q[i-1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant_q  <= id_t'(NUM_REQ - 1);
         issue_valid_q <= 1'b0;
         issue_id_q    <= '0;
         issue_ops_q   <= '0;
         tag_valid_q   <= '{default: 1'b0};
         tag_id_q      <= '{default: '0};
      end else begin
         last_grant_q  <= last_grant_d;
         issue_valid_q <= issue_valid_d;
         issue_id_q    <= issue_id_d;
         issue_ops_q   <= issue_ops_d;
         tag_valid_q   <= tag_valid_d;
         tag_id_q      <= tag_id_d;
      end
   end

   assign bus.tree_valid    = issue_valid_q;
   assign bus.tree_operands = issue_ops_q;

   adder_tree_res_fifo #(
      .Width (IdW + SumW),
      .Depth (RES_DEPTH)
   ) u_res_fifo (
      .clk          (clk),
      .rst          (rst),
      .push_i       (tag_valid_q[TREE_LATENCY-1]),
      .push_data_i  ({tag_id_q[TREE_LATENCY-1], bus.tree_sum}),
      .pop_ready_i  (bus.res_ready),
      .head_valid_o (bus.res_valid),
      .head_data_o  (head_data),
      .count_o      (fifo_count)
   );

   assign {bus.res_id, bus.res_sum} = head_data;

endmodule

// File: tb/tb_adder_tree_sched.sv
// Directed bench for adder_tree_sched with a behavioural 2-stage adder tree.
module tb_adder_tree_sched;

   localparam int unsigned W    = 6;
   localparam int unsigned N    = 4;
   localparam int unsigned TL   = 2;
   localparam int unsigned D    = 8;
   localparam int unsigned OpW  = 8 * W;
   localparam int unsigned SumW = W + 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   adder_tree_sched_if #(.ADDER_WIDTH(W), .NUM_REQ(N)) bus ();

   adder_tree_sched #(
      .ADDER_WIDTH  (W),
      .NUM_REQ      (N),
      .TREE_LATENCY (TL),
      .RES_DEPTH    (D)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Behavioural tree: no reset, so stale sums keep flowing across a scheduler reset.
   logic [SumW-1:0] tpipe [TL];

   function automatic logic [SumW-1:0] leaf_sum(input logic [OpW-1:0] ops);
      logic [SumW-1:0] s;
      s = '0;
      for (int j = 0; j < 8; j++) s = s + SumW'(ops[j*W +: W]);
      return s;
   endfunction

   always @(posedge clk) begin
      tpipe[0] <= leaf_sum(bus.tree_operands);
      for (int i = 1; i < TL; i++) tpipe[i] <= tpipe[i-1];
   end
   assign bus.tree_sum = tpipe[TL-1];

   int n_vec = 0;
   int n_err = 0;
   int accepts;
   int pops;
   logic [OpW-1:0] ops_v;

   function automatic logic [OpW-1:0] all_leaves(input int unsigned v);
      logic [OpW-1:0] r;
      for (int j = 0; j < 8; j++) r[j*W +: W] = W'(v);
      return r;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.req_valid    = '0;
      bus.req_operands = '0;
      bus.res_ready    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req_ready", 64'(bus.req_ready), 0);
      chk("rst_tree_valid", 64'(bus.tree_valid), 0);
      chk("rst_tree_ops", 64'(bus.tree_operands), 0);
      chk("rst_res_valid", 64'(bus.res_valid), 0);
      chk("rst_res_sum", 64'(bus.res_sum), 0);
      chk("rst_res_id", 64'(bus.res_id), 0);

      // Fairness: all requesters valid, requester i has every leaf = i+1.
      tick();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) bus.req_operands[i*OpW +: OpW] = all_leaves(i + 1);
      bus.res_ready = 1'b1;
      bus.req_valid = 4'hF;
      for (int k = 0; k < 8; k++) begin
         #1;
         chk("fair_grant", 64'(bus.req_ready), 64'(1 << (k % 4)));
         if (k >= 1) chk("fair_tree_ops", 64'(bus.tree_operands), 64'(all_leaves((k - 1) % 4 + 1)));
         if (k >= 4) begin
            chk("fair_res_valid", 64'(bus.res_valid), 1);
            chk("fair_res_id", 64'(bus.res_id), 64'((k - 4) % 4));
            chk("fair_res_sum", 64'(bus.res_sum), 64'(8 * ((k - 4) % 4 + 1)));
         end
         tick();
      end
      bus.req_valid = '0;
      repeat (5) tick();

      // Single request from requester 2, every leaf = 63.
      bus.res_ready = 1'b0;
      bus.req_operands[2*OpW +: OpW] = all_leaves(63);
      bus.req_valid = 4'b0100;
      #1 chk("single_ready", 64'(bus.req_ready), 4);
      tick();
      bus.req_valid = '0;
      #1;
      chk("single_tree_valid", 64'(bus.tree_valid), 1);
      chk("single_tree_ops", 64'(bus.tree_operands), 64'h0000_FFFF_FFFF_FFFF);
      tick();
      #1 chk("single_idle_tree", 64'(bus.tree_valid), 0);
      tick();
      #1 chk("single_not_yet", 64'(bus.res_valid), 0);
      tick();
      #1;
      chk("single_res_valid", 64'(bus.res_valid), 1);
      chk("single_res_sum", 64'(bus.res_sum), 504);
      chk("single_res_id", 64'(bus.res_id), 2);
      bus.res_ready = 1'b1;
      tick();
      #1 chk("single_popped", 64'(bus.res_valid), 0);

      // Sparse: requester 1 (leaves 0..7) then requester 3 alone (leaves 5).
      tick();
      for (int j = 0; j < 8; j++) ops_v[j*W +: W] = W'(j);
      bus.req_operands[1*OpW +: OpW] = ops_v;
      bus.req_operands[3*OpW +: OpW] = all_leaves(5);
      bus.req_valid = 4'b0010;
      #1 chk("sparse_r1", 64'(bus.req_ready), 2);
      tick();
      bus.req_valid = 4'b1000;
      #1 chk("sparse_r3", 64'(bus.req_ready), 8);
      tick();
      bus.req_valid = '0;
      #1 chk("sparse_tree_ops", 64'(bus.tree_operands), 64'(all_leaves(5)));
      tick();
      tick();
      #1;
      chk("sparse_res1_valid", 64'(bus.res_valid), 1);
      chk("sparse_res1_id", 64'(bus.res_id), 1);
      chk("sparse_res1_sum", 64'(bus.res_sum), 28);
      tick();
      #1;
      chk("sparse_res3_id", 64'(bus.res_id), 3);
      chk("sparse_res3_sum", 64'(bus.res_sum), 40);

      // Backpressure: requester 0 streams, consumer stalled.
      tick();
      bus.res_ready = 1'b0;
      bus.req_operands[0*OpW +: OpW] = all_leaves(1);
      bus.req_valid = 4'b0001;
      accepts = 0;
      for (int k = 0; k < 12; k++) begin
         #1;
         chk("bp_ready", 64'(bus.req_ready), (k < 8) ? 64'd1 : 64'd0);
         if (bus.req_ready[0]) accepts++;
         tick();
      end
      chk("bp_accepts", 64'(accepts), 8);
      bus.res_ready = 1'b1;
      #1;
      chk("bp_full_valid", 64'(bus.res_valid), 1);
      chk("bp_no_credit_at_pop", 64'(bus.req_ready), 0);
      tick();
      bus.res_ready = 1'b0;
      #1 chk("bp_freed_credit", 64'(bus.req_ready), 1);
      tick();
      #1 chk("bp_one_only_a", 64'(bus.req_ready), 0);
      tick();
      #1 chk("bp_one_only_b", 64'(bus.req_ready), 0);
      tick();
      // Push of that issue meets this pop at count D-1.
      bus.res_ready = 1'b1;
      #1 chk("pp_no_credit", 64'(bus.req_ready), 0);
      tick();
      bus.res_ready = 1'b0;
      #1 chk("pp_count_kept", 64'(bus.req_ready), 1);
      tick();
      #1 chk("pp_refull", 64'(bus.req_ready), 0);
      tick();
      bus.req_valid = '0;
      bus.res_ready = 1'b1;
      pops = 0;
      for (int k = 0; k < 14; k++) begin
         #1;
         if (bus.res_valid) begin
            pops++;
            chk("drain_sum", 64'(bus.res_sum), 8);
         end
         tick();
      end
      chk("drain_count", 64'(pops), 8);

      // Reset with three issues in flight and two results buffered.
      bus.res_ready = 1'b0;
      bus.req_operands[0*OpW +: OpW] = all_leaves(2);
      bus.req_valid = 4'b0001;
      repeat (5) tick();
      bus.req_valid = '0;
      #1;
      chk("pre_rst_res_valid", 64'(bus.res_valid), 1);
      chk("pre_rst_tree_valid", 64'(bus.tree_valid), 1);
      rst = 1'b1;
      #1;
      chk("mid_rst_tree_valid", 64'(bus.tree_valid), 0);
      chk("mid_rst_tree_ops", 64'(bus.tree_operands), 0);
      chk("mid_rst_res_valid", 64'(bus.res_valid), 0);
      chk("mid_rst_res_sum", 64'(bus.res_sum), 0);
      chk("mid_rst_res_id", 64'(bus.res_id), 0);
      chk("mid_rst_req_ready", 64'(bus.req_ready), 0);
      tick();
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1 chk("post_rst_no_stale", 64'(bus.res_valid), 0);
         tick();
      end
      bus.req_valid = 4'hF;
      #1 chk("post_rst_prio0", 64'(bus.req_ready), 1);
      tick();
      bus.req_valid = '0;
      bus.res_ready = 1'b1;
      repeat (6) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
